// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch controller.
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int ENTRY_W = 2 * INSTR_W;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  // True when the word index of a byte address lies inside the populated memory.
  function automatic logic word_in_range(input logic [31:0] pc, input int unsigned mem_words);
    return {2'b00, pc[31:2]} < mem_words;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue holding {pc, instr} entries with a combinational head and a flush.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head_ptr_reg;
  logic [PTR_W-1:0]   tail_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push_ok;
  logic               pop_ok;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[head_ptr_reg];

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop);
  assign pop_ok  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else if (flush) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (push_ok) tail_ptr_reg <= tail_ptr_reg + PTR_W'(1);
      if (pop_ok)  head_ptr_reg <= head_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, fills the prefetch queue and
// hands instructions to ID, with redirect flush and out-of-range fault stop.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        fault_o,
  output logic        misalign_o,
  output logic [31:0] retired_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state_reg;
  logic [31:0]        fetch_pc_reg;
  logic               misalign_reg;
  logic [31:0]        retired_reg;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_level_unused;
  logic [ENTRY_W-1:0] fifo_head;

  logic               pop;
  logic               can_push;
  logic               push;
  logic [31:0]        pc_plus4;
  logic [31:0]        redirect_target;

  assign id_valid_o = !fifo_empty;
  assign pop        = id_valid_o && id_ready_i && !redirect_i;
  assign can_push   = !fifo_full || pop;
  // Push uses the live enable, so dropping fetch_en_i suppresses the push that cycle.
  assign push       = (state_reg == S_FETCH) && fetch_en_i && can_push && !redirect_i;

  assign pc_plus4        = fetch_pc_reg + PC_STEP;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  if_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .flush (redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc_reg, imem_instr_i}),
    .count (fifo_level_unused),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      misalign_reg <= 1'b0;
      retired_reg  <= '0;
    end else begin
      misalign_reg <= 1'b0;
      if (redirect_i) begin
        fetch_pc_reg <= redirect_target;
        misalign_reg <= |redirect_pc_i[1:0];
        if (!fetch_en_i) begin
          state_reg <= S_IDLE;
        end else if (word_in_range(redirect_target, MEM_WORDS)) begin
          state_reg <= S_FETCH;
        end else begin
          state_reg <= S_FAULT;
        end
      end else begin
        if (pop) retired_reg <= retired_reg + 32'd1;
        case (state_reg)
          S_IDLE: begin
            if (fetch_en_i) begin
              state_reg <= word_in_range(fetch_pc_reg, MEM_WORDS) ? S_FETCH : S_FAULT;
            end
          end
          S_FETCH: begin
            if (!fetch_en_i) begin
              state_reg <= S_IDLE;
            end else if (push) begin
              fetch_pc_reg <= pc_plus4;
              if (!word_in_range(pc_plus4, MEM_WORDS)) state_reg <= S_FAULT;
            end
          end
          S_FAULT: begin
            state_reg <= S_FAULT;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign imem_addr_o   = fetch_pc_reg;
  assign id_instr_o    = fifo_head[INSTR_W-1:0];
  assign id_pc_o       = fifo_head[ENTRY_W-1:INSTR_W];
  assign id_pc4_o      = id_pc_o + PC_STEP;
  assign fault_o       = (state_reg == S_FAULT);
  assign misalign_o    = misalign_reg;
  assign retired_cnt_o = retired_reg;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl against a queue-based behavioural model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_WORDS = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_en_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        id_ready_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic        fault_o;
  logic        misalign_o;
  logic [31:0] retired_cnt_o;

  logic [31:0] mem [MEM_WORDS];

  // Model state: queued {pc, instr}, fetch pc, activity flags, counters.
  logic [63:0] q [$];
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  bit          m_fetching;
  bit          m_faulted;
  bit          m_misalign;
  int          n_vec = 0;
  int          n_err = 0;

  if_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_en_i   (fetch_en_i),
    .imem_addr_o  (imem_addr_o),
    .imem_instr_i (imem_instr_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_instr_o   (id_instr_o),
    .id_pc_o      (id_pc_o),
    .id_pc4_o     (id_pc4_o),
    .fault_o      (fault_o),
    .misalign_o   (misalign_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit in_range(input logic [31:0] a);
    return {2'b00, a[31:2]} < 32'(MEM_WORDS);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (in_range(a)) return mem[a[9:2]];
    return 32'hBAD0_0000 ^ a;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("id_valid", 32'(id_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_val("id_instr", id_instr_o, q[0][31:0]);
      check_val("id_pc", id_pc_o, q[0][63:32]);
      check_val("id_pc4", id_pc4_o, q[0][63:32] + 32'd4);
    end
    check_val("imem_addr", imem_addr_o, m_pc);
    check_val("fault", 32'(fault_o), 32'(m_faulted));
    check_val("misalign", 32'(misalign_o), 32'(m_misalign));
    check_val("retired", retired_cnt_o, m_retired);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = RESET_PC;
    m_retired  = 32'h0;
    m_fetching = 1'b0;
    m_faulted  = 1'b0;
    m_misalign = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit en, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit pop;
    fetch_en_i    = en;
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    pop = (q.size() != 0) && rdy;
    m_misalign = 1'b0;
    if (redir) begin
      q.delete();
      m_pc       = {rpc[31:2], 2'b00};
      m_misalign = |rpc[1:0];
      m_fetching = en && in_range(m_pc);
      m_faulted  = en && !in_range(m_pc);
    end else begin
      if (pop) begin
        void'(q.pop_front());
        m_retired++;
      end
      if (!m_fetching && !m_faulted) begin
        if (en) begin
          if (in_range(m_pc)) m_fetching = 1'b1;
          else m_faulted = 1'b1;
        end
      end else if (m_fetching) begin
        if (!en) begin
          m_fetching = 1'b0;
        end else if (q.size() < DEPTH) begin
          q.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
          if (!in_range(m_pc)) begin
            m_fetching = 1'b0;
            m_faulted  = 1'b1;
          end
        end
      end
    end
    @(negedge clk_i);
    $display("cyc en=%0d rdy=%0d redir=%0d rpc=%h | pc=%h valid=%0d id_pc=%h fault=%0d ret=%0d",
             en, rdy, redir, rpc, imem_addr_o, id_valid_o, id_pc_o, fault_o, retired_cnt_o);
    check_all();
  endtask

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003;
    mem[3] = 32'hDDDD_0004;
    model_reset();

    #1 rst_i = 1'b0;
    #2 check_all();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check_all();

    // Streaming start, then stall and release.
    repeat (6) step(1, 1, 0, 32'h0);
    repeat (5) step(1, 0, 0, 32'h0);
    repeat (4) step(1, 1, 0, 32'h0);

    // Redirect with a full queue, then a misaligned redirect.
    repeat (3) step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'h40);
    repeat (3) step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h43);
    repeat (3) step(1, 1, 0, 32'h0);

    // Run off the end of memory, sit in fault, recover by redirect.
    step(1, 1, 1, 32'h3F0);
    repeat (10) step(1, 1, 0, 32'h0);
    step(1, 1, 1, 32'h0);
    repeat (3) step(1, 1, 0, 32'h0);

    // Out-of-range redirect target, then redirect with fetch disabled.
    step(1, 1, 1, 32'h1000);
    repeat (2) step(1, 1, 0, 32'h0);
    step(0, 1, 1, 32'h20);
    repeat (2) step(0, 1, 0, 32'h0);
    repeat (3) step(1, 1, 0, 32'h0);

    repeat (600) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'($urandom_range(0, 32'h3FF));
        1:       rpc = 32'h3E0 + 32'($urandom_range(0, 31));
        2:       rpc = 32'($urandom_range(0, 32'h4FF));
        default: rpc = $urandom;
      endcase
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, rpc);
    end

    // Asynchronous reset with the queue full.
    step(1, 1, 1, 32'h100);
    repeat (3) step(1, 0, 0, 32'h0);
    #2 rst_i = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk_i);
    rst_i = 1'b1;
    check_all();
    repeat (6) step(1, 1, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
